// File: rtl/gemm_seq_ctrl.sv
// gemm_seq_ctrl: sequences weight preload, skewed activation streaming and
// result drain for a ROWS x COLS weight-stationary systolic GEMM array.
// A single cycle counter (1 in the first busy cycle) times every phase.
// Buffer strobes are decoded from it, and the array strobes are derived
// through shift-register delays.
module gemm_seq_ctrl #(
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 4,
  parameter int unsigned MAX_M  = 64,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(MAX_M+1)-1:0] num_vec,
  output logic                       busy,
  output logic                       done,
  output logic                       w_rd_en,
  output logic [ADDR_W-1:0]          w_rd_addr,
  output logic                       w_load,
  output logic                       a_rd_en,
  output logic [ADDR_W-1:0]          a_rd_addr,
  output logic [ROWS-1:0]            a_en,
  output logic [COLS-1:0]            p_wr_en,
  output logic [COLS*ADDR_W-1:0]     p_wr_addr
);

  localparam int unsigned MW = $clog2(MAX_M+1);
  localparam int unsigned CW = $clog2(MAX_M+2*ROWS+COLS+4) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [MW-1:0]   m_q, m_d;
  logic            wload_q;
  logic [ROWS-1:0] aen_q;
  logic [COLS-1:0] pwr_q;

  // State, counter and latched vector count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
    end
  end

  // Array strobes: w_load and a_en[0] lag their buffer reads by the read
  // latency, a_en skews one cycle per row, and column c writes once the
  // bottom row's activation has passed c+1 more cells.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wload_q <= 1'b0;
      aen_q   <= '0;
      pwr_q   <= '0;
    end else begin
      wload_q  <= w_rd_en;
      aen_q[0] <= a_rd_en;
      for (int unsigned r = 1; r < ROWS; r++) aen_q[r] <= aen_q[r-1];
      pwr_q[0] <= aen_q[ROWS-1];
      for (int unsigned c = 1; c < COLS; c++) pwr_q[c] <= pwr_q[c-1];
    end
  end

  // Next-state logic and buffer read strobes decoded from the cycle counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_d       = m_q;
    w_rd_en   = 1'b0;
    w_rd_addr = '0;
    a_rd_en   = 1'b0;
    a_rd_addr = '0;
    done      = 1'b0;
    busy      = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          if (num_vec != '0) begin
            state_d = S_LOAD_W;
            m_d     = num_vec;
            cnt_d   = CW'(1);
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_LOAD_W: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q <= CW'(ROWS)) begin
          w_rd_en   = 1'b1;
          w_rd_addr = ADDR_W'(cnt_q - CW'(1));
        end
        if (cnt_q == CW'(ROWS+1)) state_d = S_STREAM;
      end
      S_STREAM: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q <= CW'(ROWS+1) + CW'(m_q)) begin
          a_rd_en   = 1'b1;
          a_rd_addr = ADDR_W'(cnt_q - CW'(ROWS+2));
        end
        if (cnt_q == CW'(ROWS+2) + CW'(m_q)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(2*ROWS+COLS+1) + CW'(m_q)) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Column c writes vector i at counter value 2*ROWS+3+c+i.
  always_comb begin
    p_wr_addr = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (pwr_q[c]) p_wr_addr[c*ADDR_W +: ADDR_W] = ADDR_W'(cnt_q - CW'(2*ROWS+3+c));
    end
  end

  assign w_load  = wload_q;
  assign a_en    = aen_q;
  assign p_wr_en = pwr_q;

endmodule

// File: tb/tb_gemm_seq_ctrl.sv
// Self-checking bench for gemm_seq_ctrl: table of commands plus randomized
// commands, each checked cycle by cycle against a timing model.
module tb_gemm_seq_ctrl;

  localparam int R    = 4;
  localparam int C    = 4;
  localparam int MAXM = 64;
  localparam int AW   = 8;
  localparam int NW   = $clog2(MAXM+1);

  logic            clk, rst, start;
  logic [NW-1:0]   num_vec;
  logic            busy, done, w_rd_en, w_load, a_rd_en;
  logic [AW-1:0]   w_rd_addr, a_rd_addr;
  logic [R-1:0]    a_en;
  logic [C-1:0]    p_wr_en;
  logic [C*AW-1:0] p_wr_addr;

  int checks = 0;
  int errors = 0;

  gemm_seq_ctrl #(.ROWS(R), .COLS(C), .MAX_M(MAXM), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
    .busy(busy), .done(done),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_load(w_load),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_en(a_en),
    .p_wr_en(p_wr_en), .p_wr_addr(p_wr_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic int done_cycle(input int m);
    return (m == 0) ? 1 : (R + 3) + m + R + C - 1;
  endfunction

  // Compare every output at cycle k after the accepting edge of an m-vector
  // command; with quiet=1 everything must be 0.
  task automatic check_cycle(input int k, input int m, input bit quiet, input string tag);
    logic          e_busy, e_done, e_wen, e_wl, e_aen;
    logic [AW-1:0] e_wa, e_aa;
    logic [R-1:0]  e_ae;
    logic [C-1:0]  e_pe;
    logic [C*AW-1:0] e_pa;
    int dk, e0, i;
    dk = done_cycle(m);
    e0 = R + 3;
    e_busy = 0; e_done = 0; e_wen = 0; e_wl = 0; e_aen = 0;
    e_wa = '0; e_aa = '0; e_ae = '0; e_pe = '0; e_pa = '0;
    if (!quiet) begin
      e_busy = (k >= 1 && k <= dk);
      e_done = (k == dk);
      if (m > 0) begin
        if (k >= 1 && k <= R) begin e_wen = 1; e_wa = AW'(k - 1); end
        e_wl = (k >= 2 && k <= R + 1);
        if (k >= R + 2 && k <= R + 1 + m) begin e_aen = 1; e_aa = AW'(k - R - 2); end
        for (int r = 0; r < R; r++) e_ae[r] = (k >= e0 + r && k <= e0 + r + m - 1);
        for (int c = 0; c < C; c++) begin
          i = k - (e0 + R + c);
          if (i >= 0 && i < m) begin
            e_pe[c] = 1'b1;
            e_pa[c*AW +: AW] = AW'(i);
          end
        end
      end
    end
    chk($sformatf("%s@%0d busy", tag, k), 64'(busy), 64'(e_busy));
    chk($sformatf("%s@%0d done", tag, k), 64'(done), 64'(e_done));
    chk($sformatf("%s@%0d w_rd_en", tag, k), 64'(w_rd_en), 64'(e_wen));
    chk($sformatf("%s@%0d w_rd_addr", tag, k), 64'(w_rd_addr), 64'(e_wa));
    chk($sformatf("%s@%0d w_load", tag, k), 64'(w_load), 64'(e_wl));
    chk($sformatf("%s@%0d a_rd_en", tag, k), 64'(a_rd_en), 64'(e_aen));
    chk($sformatf("%s@%0d a_rd_addr", tag, k), 64'(a_rd_addr), 64'(e_aa));
    chk($sformatf("%s@%0d a_en", tag, k), 64'(a_en), 64'(e_ae));
    chk($sformatf("%s@%0d p_wr_en", tag, k), 64'(p_wr_en), 64'(e_pe));
    chk($sformatf("%s@%0d p_wr_addr", tag, k), 64'(p_wr_addr), 64'(e_pa));
  endtask

  // Issue one command; called and returns at a negedge. Returns at the cycle
  // after done, so a following call exercises back-to-back acceptance.
  task automatic run_cmd(input int m, input int pulse_k, input int rst_k,
                         input int exp_done, input string tag);
    int seen_done, dk;
    seen_done = -1;
    dk = done_cycle(m);
    start = 1'b1;
    num_vec = NW'(m);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= dk + 1; k++) begin
      check_cycle(k, m, 1'b0, tag);
      if (done === 1'b1 && seen_done < 0) seen_done = k;
      if (k == pulse_k) begin
        start = 1'b1;
        num_vec = NW'($urandom_range(0, MAXM));
      end else begin
        start = 1'b0;
      end
      if (k == rst_k) begin
        #1 rst = 1'b1;
        #1 check_cycle(0, m, 1'b1, {tag, "_rst"});
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 30; j++) begin
          @(negedge clk);
          chk($sformatf("%s post_rst done %0d", tag, j), 64'(done), 64'd0);
          chk($sformatf("%s post_rst busy %0d", tag, j), 64'(busy), 64'd0);
        end
        return;
      end
      if (k <= dk) @(negedge clk);
    end
    start = 1'b0;
    chk($sformatf("%s done_cycle", tag), 64'(seen_done), 64'(exp_done));
  endtask

  typedef struct {
    int m;
    int pulse_k;
    int rst_k;
    int exp_done;
  } vec_t;

  initial begin
    vec_t tbl[7];
    int m, pk;
    tbl = '{
      '{2,  -1, -1, 16},
      '{0,  -1, -1, 1},
      '{64, -1, -1, 78},
      '{2,   5, -1, 16},
      '{3,  -1, -1, 17},
      '{8,  -1,  9, -1},
      '{8,  -1, -1, 22}
    };
    rst = 1'b0;
    start = 1'b0;
    num_vec = '0;

    // Asynchronous reset between edges: outputs clear without a clock edge.
    #2 rst = 1'b1;
    #1 check_cycle(0, 0, 1'b1, "rst_async");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_cycle(0, 0, 1'b1, "rst_idle");

    for (int t = 0; t < 7; t++)
      run_cmd(tbl[t].m, tbl[t].pulse_k, tbl[t].rst_k, tbl[t].exp_done, $sformatf("tbl%0d", t));

    for (int t = 0; t < 10; t++) begin
      m  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, MAXM));
      pk = (m > 0) ? int'($urandom_range(1, done_cycle(m) - 1)) : -1;
      run_cmd(m, pk, -1, done_cycle(m), $sformatf("rnd%0d_m%0d", t, m));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gemm_seq_ctrl.md
# gemm_seq_ctrl

Sequencer for the weight-stationary systolic GEMM array built from `mac` cells, ROWS x COLS. One `start` command runs three phases: weight preload, skewed activation streaming, and result drain. The block drives the weight-buffer and activation-buffer read ports, the per-row `A_en`/`W_en` strobes, and the per-column result-buffer writes. It sits between the core's GEMM command register and the array datapath.

## Interface
- ROWS, 4, array rows; activations are skewed across these.
- COLS, 4, array columns; results drain out of these.
- MAX_M, 64, maximum activation vectors per command.
- ADDR_W, 8, buffer address width; must satisfy 2^ADDR_W >= MAX_M and >= ROWS.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- num_vec  in  $clog2(MAX_M+1)  vector count M, latched at accepted start.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle completion pulse.
- w_rd_en  out  1  weight-buffer read strobe; read latency is 1.
- w_rd_addr  out  ADDR_W  weight row address.
- w_load  out  1  drives `W_en` of the top array row.
- a_rd_en  out  1  activation-buffer read strobe; read latency is 1.
- a_rd_addr  out  ADDR_W  activation vector index.
- a_en  out  ROWS  `A_en` for column 0 of row r (bit r).
- p_wr_en  out  COLS  result-buffer write strobe for column c (bit c).
- p_wr_addr  out  COLS*ADDR_W  slice c holds the vector index written by column c.

## Operation
- States:
  - IDLE
  - LOAD_W: ROWS+1 cycles.
  - STREAM: M cycles of reads, plus 1.
  - DRAIN
  - DONE: 1 cycle.
- IDLE:
  - start=1 and M>0 -> LOAD_W, with M latched.
  - start=1 and M=0 -> DONE; no buffer or array strobes fire.
- LOAD_W:
  - w_rd_en is high for ROWS cycles with w_rd_addr = 0..ROWS-1.
  - w_load is w_rd_en delayed by 1 cycle.
  - The state then moves to STREAM.
- STREAM:
  - a_rd_en is high for M cycles with a_rd_addr = 0..M-1.
  - a_en[0] is a_rd_en delayed by 1; a_en[r] is a_en[0] delayed by r more cycles (shift-register skew).
  - After the last a_rd_en the state moves to DRAIN.
- DRAIN:
  - Counts until the final p_wr_en[COLS-1] has been issued, then goes to DONE.
- DONE: done=1 for one cycle, then IDLE.
- start is ignored while busy=1; it is not queued.
- Result schedule: column c writes vector i when P for vector i leaves the bottom row, with p_wr_addr slice c = i.
- Counters saturate at no value; sized to MAX_M+ROWS+COLS. Address counters never wrap because M <= MAX_M < 2^ADDR_W.

## Timing
- Reset values: all outputs 0, state IDLE, skew pipelines and counters cleared.
- Assertion of rst mid-operation aborts immediately; no done pulse follows.
- Let T be the edge that samples an accepted start. Let E0 = T+ROWS+3, the first a_en[0] cycle.
- LOAD_W phase:
  - w_rd_en is high in cycles T+1..T+ROWS.
  - w_load is high in cycles T+2..T+ROWS+1.
- STREAM phase:
  - a_rd_en is high in cycles T+ROWS+2..T+ROWS+1+M.
  - a_en[r] is high in cycles E0+r..E0+r+M-1.
- Results: p_wr_en[c] for vector i is high at cycle E0+i+ROWS+c. Each column asserts for M consecutive cycles.
- done is high at cycle E0+M+ROWS+COLS-1. busy falls in the following cycle, and IDLE can accept start in that same cycle.
- Zero-length command (M=0): done is high at T+1 and busy is high only at T+1.

## Test plan
- Reset: assert rst asynchronously between clock edges. Every output reads 0 immediately; release, and the block sits in IDLE with busy=0.
- Defaults, M=2, start at T=0:
  - w_rd_addr 0..3 in cycles 1-4; w_load in cycles 2-5.
  - a_rd_en in cycles 6-7; a_en[0] in cycles 7-8; a_en[3] in cycles 10-11.
  - p_wr_en[0] in cycles 11-12 with addr 0,1; p_wr_en[3] in cycles 14-15.
  - done at cycle 16.
- M=0: done at cycle 1. No strobes on w_rd_en, a_rd_en, a_en or p_wr_en.
- M=MAX_M=64: a_rd_addr runs 0..63 with no wrap; p_wr_addr slice 3 ends at 63; done at cycle 7+64+4+4-1 = 78.
- start pulsed at cycle 5 during a run: it is ignored and the schedule is unchanged. A start at the cycle after done is accepted.
- rst asserted at cycle 9 of an M=8 run: all outputs are 0 at once and no done follows. A fresh start after reset gives the full, correct schedule.
